// File: rtl/dht11_emulador.sv
// dht11_emulador: DHT11 sensor responder for loopback and controller testbenches.
// Detects the host start pulse on dht_in and answers with the DHT11 preamble
// followed by a 40-bit frame {umidade_int, umidade_dec, temp_int, temp_dec, checksum}.
// Ports: clock, reset (async active-low), habilita (enable start detection),
// dht_in (raw bus level), umidade_int/umidade_dec/temp_int/temp_dec (frame bytes),
// dht_oe (1 = pull bus low), ocupado (response in progress),
// fim_resposta (one-cycle pulse at end of response).
// Optional: DHT11_EMU_ERRO_CHECKSUM_EN adds injeta_erro, which inverts the sent checksum.
module dht11_emulador #(
    parameter int CICLOS_US      = 50,
    parameter int T_START_MIN_US = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       dht_in,
    input  logic [7:0] umidade_int,
    input  logic [7:0] umidade_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
    input  logic       injeta_erro,
`endif
    output logic       dht_oe,
    output logic       ocupado,
    output logic       fim_resposta
);
    typedef enum logic [3:0] {
        OCIOSO, MEDE_START, ESPERA_SUBIDA, ATRASO, RESP_BAIXO,
        RESP_ALTO, BIT_BAIXO, BIT_ALTO, FIM_BAIXO
    } estado_t;

    estado_t     estado_q, estado_d;
    logic        sync1_q, s_q;
    logic [15:0] presc_q, presc_d, us_q, us_d, dur;
    logic [5:0]  bit_q, bit_d;
    logic [39:0] quadro_q, quadro_d;
    logic        dht_oe_q, dht_oe_d, fim_q, fim_d;
    logic        tick, fim_fase, entra;
    logic [7:0]  soma, checksum;

    assign soma = umidade_int + umidade_dec + temp_int + temp_dec;
`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
    assign checksum = injeta_erro ? ~soma : soma;
`else
    assign checksum = soma;
`endif

    assign tick = presc_q == 16'(CICLOS_US - 1);
    assign dur  = (estado_q == MEDE_START) ? 16'(T_START_MIN_US) :
                  (estado_q == ATRASO) ? 16'd30 :
                  (estado_q == RESP_BAIXO || estado_q == RESP_ALTO) ? 16'd80 :
                  (estado_q == BIT_ALTO) ? (quadro_q[39] ? 16'd70 : 16'd26) : 16'd50;
    assign fim_fase = tick && (us_q == dur - 16'd1);

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:        if (habilita && !s_q) estado_d = MEDE_START;
            MEDE_START:    if (s_q) estado_d = OCIOSO;
                           else if (fim_fase) estado_d = ESPERA_SUBIDA;
            ESPERA_SUBIDA: if (s_q) estado_d = ATRASO;
            ATRASO:        if (fim_fase) estado_d = RESP_BAIXO;
            RESP_BAIXO:    if (fim_fase) estado_d = RESP_ALTO;
            RESP_ALTO:     if (fim_fase) estado_d = BIT_BAIXO;
            BIT_BAIXO:     if (fim_fase) estado_d = BIT_ALTO;
            BIT_ALTO:      if (fim_fase) estado_d = (bit_q == 6'd39) ? FIM_BAIXO : BIT_BAIXO;
            FIM_BAIXO:     if (fim_fase) estado_d = OCIOSO;
            default:       estado_d = OCIOSO;
        endcase
        entra = estado_d != estado_q;
        // The OCIOSO cycle that first saw the low already counts toward the start pulse,
        // so MEDE_START is entered with one cycle pre-counted.
        presc_d = entra ? ((estado_d == MEDE_START && CICLOS_US > 1) ? 16'd1 : 16'd0)
                        : (tick ? 16'd0 : presc_q + 16'd1);
        us_d    = entra ? ((estado_d == MEDE_START && CICLOS_US == 1) ? 16'd1 : 16'd0)
                        : us_q + {15'd0, tick};
        bit_d   = (entra && estado_d == ATRASO) ? 6'd0 :
                  (estado_q == BIT_ALTO && fim_fase) ? bit_q + 6'd1 : bit_q;
        quadro_d = (estado_q == MEDE_START && estado_d == ESPERA_SUBIDA) ?
                       {umidade_int, umidade_dec, temp_int, temp_dec, checksum} :
                   (estado_q == BIT_ALTO && fim_fase) ? {quadro_q[38:0], 1'b0} : quadro_q;
        dht_oe_d = estado_d == RESP_BAIXO || estado_d == BIT_BAIXO || estado_d == FIM_BAIXO;
        fim_d    = estado_q == FIM_BAIXO && fim_fase;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b1;
            s_q      <= 1'b1;
            estado_q <= OCIOSO;
            presc_q  <= '0;
            us_q     <= '0;
            bit_q    <= '0;
            quadro_q <= '0;
            dht_oe_q <= 1'b0;
            fim_q    <= 1'b0;
        end else begin
            sync1_q  <= dht_in;
            s_q      <= sync1_q;
            estado_q <= estado_d;
            presc_q  <= presc_d;
            us_q     <= us_d;
            bit_q    <= bit_d;
            quadro_q <= quadro_d;
            dht_oe_q <= dht_oe_d;
            fim_q    <= fim_d;
        end
    end

    assign dht_oe       = dht_oe_q;
    assign fim_resposta = fim_q;
    assign ocupado      = !(estado_q == OCIOSO || estado_q == MEDE_START);
endmodule

// File: tb/tb_dht11_emulador.sv
// tb_dht11_emulador: scoreboard bench for dht11_emulador with CICLOS_US=1.
module tb_dht11_emulador;
    logic clock = 1'b0, reset = 1'b0, habilita = 1'b0, dht_in = 1'b1;
    logic [7:0] ui = 8'h37, ud = 8'h00, ti = 8'h19, td = 8'h00;
`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
    logic injeta_erro = 1'b0;
`endif
    logic dht_oe, ocupado, fim_resposta;
    int n_checks = 0, n_fail = 0, cyc = 0;

    typedef struct {
        logic [39:0] frame;
        int          rise;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    dht11_emulador #(.CICLOS_US(1), .T_START_MIN_US(1000)) dut (
        .clock(clock), .reset(reset), .habilita(habilita), .dht_in(dht_in),
        .umidade_int(ui), .umidade_dec(ud), .temp_int(ti), .temp_dec(td),
`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
        .injeta_erro(injeta_erro),
`endif
        .dht_oe(dht_oe), .ocupado(ocupado), .fim_resposta(fim_resposta)
    );

    function automatic void check(string name, longint act, longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference frame from the protocol rules: bytes in order plus mod-256 sum.
    function automatic logic [39:0] model_frame(logic [7:0] a, b, c, d, logic inj);
        int sum = int'(a) + int'(b) + int'(c) + int'(d);
        logic [7:0] cs = 8'(sum % 256);
        if (inj) cs = ~cs;
        return {a, b, c, d, cs};
    endfunction

    // Monitor: measures run lengths of dht_oe and decodes each response.
    int run = 0, hi_cnt = 0, nbits = 0, lat = 0;
    logic prev = 1'b0;
    logic [39:0] got = '0;
    always @(negedge clock) begin
        if (!reset) begin
            run = 0; hi_cnt = 0; nbits = 0; prev = 1'b0; got = '0;
        end else begin
            if (dht_oe != prev) begin
                if (prev) begin
                    check("low_pulse_len", run, hi_cnt == 0 ? 80 : 50);
                    hi_cnt++;
                end else if (hi_cnt == 0) begin
                    lat = cyc - (exp_q.size() != 0 ? exp_q[0].rise : 0);
                end else if (hi_cnt == 1) begin
                    check("preamble_high_len", run, 80);
                end else begin
                    check("bit_high_len_valid", (run == 26 || run == 70) ? 1 : 0, 1);
                    got = {got[38:0], run == 70};
                    nbits++;
                end
                prev = dht_oe;
                run = 1;
            end else begin
                run++;
            end
            if (fim_resposta) begin
                if (exp_q.size() == 0) check("fim_without_request", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("first_drive_latency", lat, 33);
                    check("bit_count", nbits, 40);
                    check("low_pulse_count", hi_cnt, 42);
                    check("frame", got, e.frame);
                end
                hi_cnt = 0; nbits = 0; got = '0;
            end
        end
    end

    task automatic start_pulse(int low_len);
        @(posedge clock); #1 dht_in = 1'b0;
        repeat (low_len) @(posedge clock);
        #1 dht_in = 1'b1;
    endtask

    task automatic send_frame(int low_len, logic inj);
        start_pulse(low_len);
        exp_q.push_back('{model_frame(ui, ud, ti, td, inj), cyc});
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_q.size() != 0 && t < 8000) begin
            @(posedge clock);
            t++;
        end
        check("frame_timeout", exp_q.size(), 0);
        exp_q.delete();
        repeat (5) @(posedge clock);
    endtask

    task automatic quiet(int n);
        int act = 0;
        repeat (n) begin
            @(negedge clock);
            act |= int'(dht_oe | ocupado);
        end
        check("quiet_bus", act, 0);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        check("reset_dht_oe", dht_oe, 0);
        check("reset_ocupado", ocupado, 0);
        exp_q.delete();
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_dht_oe", dht_oe, 0);
        check("reset_ocupado", ocupado, 0);
        check("reset_fim", fim_resposta, 0);
        @(posedge clock); #1 reset = 1'b1; habilita = 1'b1;
        repeat (3) @(posedge clock);

        send_frame(1000, 1'b0);
        wait_done();

        fork start_pulse(500); quiet(1600); join

        habilita = 1'b0;
        fork start_pulse(2000); quiet(2200); join
        habilita = 1'b1;
        send_frame(1000, 1'b0);
        wait_done();

        send_frame(1000, 1'b0);
        repeat (480) @(posedge clock);
        check("snapshot_in_bit_low", dht_oe, 1);
        ti = 8'h20;
        wait_done();
        ti = 8'h19;

        send_frame(1000, 1'b0);
        repeat (248) @(posedge clock);
        check("in_bit_high_ocupado", ocupado, 1);
        pulse_reset();
        send_frame(1000, 1'b0);
        repeat (60) @(posedge clock);
        check("in_resp_low_dht_oe", dht_oe, 1);
        pulse_reset();
        send_frame(1000, 1'b0);
        wait_done();

        for (int i = 0; i < 3; i++) begin
            ui = 8'($urandom); ud = 8'($urandom); ti = 8'($urandom); td = 8'($urandom);
            send_frame(1000 + int'($urandom_range(0, 300)), 1'b0);
            if (i == 1) begin
                repeat (300) @(posedge clock);
                habilita = 1'b0;
            end
            wait_done();
            habilita = 1'b1;
        end

`ifdef DHT11_EMU_ERRO_CHECKSUM_EN
        ui = 8'h37; ud = 8'h00; ti = 8'h19; td = 8'h00;
        injeta_erro = 1'b1;
        send_frame(1000, 1'b1);
        @(posedge clock); #1 injeta_erro = 1'b0;
        wait_done();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
